// File: rtl/cache_arb_pkg.sv
// Shared types and sizes for the L1-to-bridge memory port arbiter.
// Line addresses are byte addresses with the offset bits cleared.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int OFF_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_ICACHE,
    OWN_DCACHE
  } arb_owner_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The tie-break pointer moves only when the
// caller reports that the grant was actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // prio_reg=1 lets index 1 (dcache) win the next tie
  logic prio_reg;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = prio_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b1;
    end else if (update && (|gnt)) begin
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises icache refills, dcache refills and dcache victim writebacks onto
// one line-granular memory port; writebacks first, reads round-robin.
module cache_mem_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_rd_req,
  input  logic [ADDR_W-1:0] icache_rd_addr,
  output logic              icache_rd_addr_ok,
  output logic              icache_rd_valid,
  output logic [LINE_W-1:0] icache_rd_data,
  input  logic              dcache_rd_req,
  input  logic [ADDR_W-1:0] dcache_rd_addr,
  output logic              dcache_rd_addr_ok,
  output logic              dcache_rd_valid,
  output logic [LINE_W-1:0] dcache_rd_data,
  input  logic              dcache_wr_req,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [LINE_W-1:0] dcache_wr_data,
  output logic              dcache_wr_addr_ok,
  output logic              dcache_wr_done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_addr_ok,
  input  logic              mem_return_en,
  input  logic [LINE_W-1:0] mem_return_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_addr_ok,
  input  logic              mem_wr_done
);

  arb_state_t        state_reg, state_next;
  arb_owner_t        owner_reg, latch_owner;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] rd_data_reg [2];
  logic [1:0]        rd_valid_reg;
  logic              wr_done_reg;

  logic [1:0]        rd_req_vec, rd_gnt;
  logic              rr_update, latch_en, latch_wr, rd_accept, wr_complete;
  logic [1:0]        ret_hit;

  assign rd_req_vec = {dcache_rd_req, icache_rd_req};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (rd_req_vec),
    .update (rr_update),
    .gnt    (rd_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    icache_rd_addr_ok = 1'b0;
    dcache_rd_addr_ok = 1'b0;
    dcache_wr_addr_ok = 1'b0;
    rr_update         = 1'b0;
    latch_en          = 1'b0;
    latch_wr          = 1'b0;
    latch_owner       = OWN_ICACHE;
    mem_rd_req        = 1'b0;
    mem_wr_req        = 1'b0;
    rd_accept         = 1'b0;
    wr_complete       = 1'b0;
    case (state_reg)
      IDLE: begin
        // no grant may be acknowledged while reset holds the datapath
        if (rst_n) begin
          if (dcache_wr_req) begin
            dcache_wr_addr_ok = 1'b1;
            latch_en          = 1'b1;
            latch_wr          = 1'b1;
            latch_owner       = OWN_DCACHE;
            state_next        = WR_ADDR;
          end else if (|rd_req_vec) begin
            rr_update         = 1'b1;
            latch_en          = 1'b1;
            latch_owner       = rd_gnt[1] ? OWN_DCACHE : OWN_ICACHE;
            icache_rd_addr_ok = rd_gnt[0];
            dcache_rd_addr_ok = rd_gnt[1];
            state_next        = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        mem_rd_req = 1'b1;
        if (mem_rd_addr_ok) begin
          if (mem_return_en) begin
            rd_accept  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        if (mem_return_en) begin
          rd_accept  = 1'b1;
          state_next = IDLE;
        end
      end
      WR_ADDR: begin
        mem_wr_req = 1'b1;
        if (mem_wr_addr_ok) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (mem_wr_done) begin
          wr_complete = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      owner_reg <= OWN_ICACHE;
    end else if (latch_en) begin
      owner_reg <= latch_owner;
      if (latch_wr) begin
        addr_reg  <= line_align(dcache_wr_addr);
        wdata_reg <= dcache_wr_data;
      end else if (latch_owner == OWN_DCACHE) begin
        addr_reg <= line_align(dcache_rd_addr);
      end else begin
        addr_reg <= line_align(icache_rd_addr);
      end
    end
  end

  // One return channel per read requester; index matches arb_owner_t
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    localparam arb_owner_t CH_OWNER = (gi == 0) ? OWN_ICACHE : OWN_DCACHE;
    assign ret_hit[gi] = rd_accept && (owner_reg == CH_OWNER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= '0;
      wr_done_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rd_data_reg[i] <= '0;
      end
    end else begin
      rd_valid_reg <= ret_hit;
      wr_done_reg  <= wr_complete;
      for (int i = 0; i < 2; i++) begin
        if (ret_hit[i]) begin
          rd_data_reg[i] <= mem_return_data;
        end
      end
    end
  end

  assign icache_rd_valid = rd_valid_reg[0];
  assign dcache_rd_valid = rd_valid_reg[1];
  assign icache_rd_data  = rd_data_reg[0];
  assign dcache_rd_data  = rd_data_reg[1];
  assign dcache_wr_done  = wr_done_reg;
  assign mem_rd_addr     = addr_reg;
  assign mem_wr_addr     = addr_reg;
  assign mem_wr_data     = wdata_reg;

endmodule
